char_dmg_arbiter: RTL and testbench

- Sequences all changes to player HP. Sources are damage requesters (boss contact, boss projectiles, arena hazards) and a heal source.
- Round-robin arbitration grants at most one damage request per cycle. Applies invulnerability frames counted on frame_tick and detects death.
- Drives char_hp into the character wrapper (hearts display and class draw logic). Sits between the collision/boss logic and the character datapath.

---
 rtl/char_pkg.sv | 26 ++
 rtl/char_rr_arb.sv | 35 +++
 rtl/char_dmg_arbiter.sv | 175 +++++++++++++++++
 tb/tb_char_dmg_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared types and constants for the character damage arbiter.
package char_pkg;

    localparam int unsigned HP_W     = 4;
    localparam logic [1:0]  GAME_RUN = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIVE  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } char_dmg_state_t;

    // Heal add performed one bit wider so overflow can never wrap past the cap.
    function automatic logic [HP_W-1:0] hp_add_sat(input logic [HP_W-1:0] hp,
                                                   input logic [HP_W-1:0] amt,
                                                   input logic [HP_W-1:0] max_hp);
        logic [HP_W:0] sum;
        sum = {1'b0, hp} + {1'b0, amt};
        if (sum > {1'b0, max_hp}) begin
            return max_hp;
        end
        return sum[HP_W-1:0];
    endfunction

endpackage

// File: rtl/char_rr_arb.sv
// Combinational round-robin picker: first asserted req at or above ptr, with wrap-around.
module char_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       valid
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr and i are both below NUM_REQ, so one subtraction is enough to wrap.
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_dmg_arbiter.sv
// Player HP sequencer: round-robin damage arbitration, i-frames, heal and death detection.
// Optional applied-hit counter enabled by defining CHAR_DMG_HITCNT_EN.
module char_dmg_arbiter
    import char_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MAX_HP  = 8,
    parameter int unsigned IFRAMES = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic [1:0]           game_active,
    input  logic                 game_start,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_amt,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 heal_valid,
    input  logic [3:0]           heal_amt,
    output logic [HP_W-1:0]      char_hp,
    output logic                 invuln,
    output logic                 hit_pulse,
    output logic                 char_dead,
    output logic [7:0]           hit_count
);

    localparam int unsigned     PTR_W    = $clog2(NUM_REQ);
    localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);
    localparam logic [7:0]      IFRAMES_V = 8'(IFRAMES);

    char_dmg_state_t      state_q, state_d;
    logic [HP_W-1:0]      hp_q, hp_d;
    logic [7:0]           iframe_q, iframe_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 hit_q, hit_d;
    logic                 invuln_q, dead_q;

    logic [NUM_REQ-1:0]   grant;
    logic                 grant_valid;
    logic [PTR_W-1:0]     win_idx;
    logic [3:0]           win_amt;
    logic [PTR_W-1:0]     ptr_next;
    logic [HP_W-1:0]      heal_eff;

    char_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        win_idx = '0;
        win_amt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx = PTR_W'(i);
                win_amt = req_amt[4*i +: 4];
            end
        end
    end

    assign ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    assign heal_eff = heal_valid ? heal_amt : '0;

    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        iframe_d = iframe_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        hit_d    = 1'b0;

        if (game_start) begin
            state_d  = ALIVE;
            hp_d     = MAX_HP_V;
            iframe_d = '0;
            ptr_d    = '0;
            ack_d    = req_valid;
        end else if (game_active != GAME_RUN) begin
            // Frozen: everything holds, no acks, frame_tick ignored.
        end else begin
            unique case (state_q)
                IDLE, DEAD: begin
                    ack_d = req_valid;
                end
                ALIVE: begin
                    if (grant_valid) begin
                        ack_d = grant;
                        ptr_d = ptr_next;
                    end
                    if (grant_valid && (win_amt != '0)) begin
                        hit_d = 1'b1;
                        if (win_amt >= hp_q) begin
                            hp_d    = '0;
                            state_d = DEAD;
                        end else begin
                            hp_d     = hp_add_sat(hp_q - win_amt, heal_eff, MAX_HP_V);
                            state_d  = INVULN;
                            iframe_d = IFRAMES_V;
                        end
                    end else begin
                        hp_d = hp_add_sat(hp_q, heal_eff, MAX_HP_V);
                    end
                end
                INVULN: begin
                    // Winner is consumed but its damage is dropped.
                    if (grant_valid) begin
                        ack_d = grant;
                        ptr_d = ptr_next;
                    end
                    hp_d = hp_add_sat(hp_q, heal_eff, MAX_HP_V);
                    if (frame_tick) begin
                        if (iframe_q == 8'd1) begin
                            state_d  = ALIVE;
                            iframe_d = '0;
                        end else begin
                            iframe_d = iframe_q - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            hp_q     <= '0;
            iframe_q <= '0;
            ptr_q    <= '0;
            ack_q    <= '0;
            hit_q    <= 1'b0;
            invuln_q <= 1'b0;
            dead_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            iframe_q <= iframe_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            hit_q    <= hit_d;
            invuln_q <= (state_d == INVULN);
            dead_q   <= (state_d == DEAD);
        end
    end

`ifdef CHAR_DMG_HITCNT_EN
    logic [7:0] hit_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q <= '0;
        end else if (game_start) begin
            hit_cnt_q <= '0;
        end else if (hit_d && (hit_cnt_q != 8'hFF)) begin
            hit_cnt_q <= hit_cnt_q + 8'd1;
        end
    end

    assign hit_count = hit_cnt_q;
`else
    assign hit_count = '0;
`endif

    assign char_hp   = hp_q;
    assign req_ack   = ack_q;
    assign hit_pulse = hit_q;
    assign invuln    = invuln_q;
    assign char_dead = dead_q;

endmodule

// File: tb/tb_char_dmg_arbiter.sv
// Directed self-checking bench for char_dmg_arbiter (default parameters).
module tb_char_dmg_arbiter;
    import char_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_active;
    logic        game_start;
    logic [3:0]  req_valid;
    logic [15:0] req_amt;
    logic [3:0]  req_ack;
    logic        heal_valid;
    logic [3:0]  heal_amt;
    logic [3:0]  char_hp;
    logic        invuln;
    logic        hit_pulse;
    logic        char_dead;
    logic [7:0]  hit_count;

    int checks = 0;
    int errors = 0;

    char_dmg_arbiter #(
        .NUM_REQ (4),
        .MAX_HP  (8),
        .IFRAMES (60)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .game_active (game_active),
        .game_start  (game_start),
        .req_valid   (req_valid),
        .req_amt     (req_amt),
        .req_ack     (req_ack),
        .heal_valid  (heal_valid),
        .heal_amt    (heal_amt),
        .char_hp     (char_hp),
        .invuln      (invuln),
        .hit_pulse   (hit_pulse),
        .char_dead   (char_dead),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic do_start();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (char_hp !== 4'd0) begin errors++; $display("FAIL rst_hp: got %0d want 0", char_hp); end
        checks++; if (invuln !== 1'b0 || char_dead !== 1'b0 || hit_pulse !== 1'b0) begin
            errors++; $display("FAIL rst_flags: inv=%b dead=%b hit=%b want 0", invuln, char_dead, hit_pulse); end
        checks++; if (req_ack !== 4'b0 || hit_count !== 8'd0) begin
            errors++; $display("FAIL rst_ack_cnt: ack=%b cnt=%0d want 0", req_ack, hit_count); end
        rst = 1'b1;
        step();
        // IDLE: requests are acked and dropped, heal ignored
        req_valid = 4'b0101; req_amt = 16'h3333; heal_valid = 1'b1; heal_amt = 4'd5;
        step();
        req_valid = 4'b0; heal_valid = 1'b0;
        checks++; if (req_ack !== 4'b0101) begin errors++; $display("FAIL idle_ack: got %b want 0101", req_ack); end
        checks++; if (char_hp !== 4'd0 || hit_pulse !== 1'b0) begin
            errors++; $display("FAIL idle_hp: hp=%0d hit=%b want 0/0", char_hp, hit_pulse); end
        // game_start discards pending requests
        req_valid = 4'b1010; req_amt = 16'h1111;
        do_start();
        req_valid = 4'b0;
        checks++; if (char_hp !== 4'd8) begin errors++; $display("FAIL start_hp: got %0d want 8", char_hp); end
        checks++; if (req_ack !== 4'b1010) begin errors++; $display("FAIL start_ack: got %b want 1010", req_ack); end
        checks++; if (invuln !== 1'b0 || char_dead !== 1'b0 || hit_pulse !== 1'b0) begin
            errors++; $display("FAIL start_flags: inv=%b dead=%b hit=%b want 0", invuln, char_dead, hit_pulse); end
    endtask

    task automatic test_single_hit();
        req_valid = 4'b0100; req_amt = 16'h0300;
        step();
        req_valid = 4'b0;
        checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL hit_ack: got %b want 0100", req_ack); end
        checks++; if (char_hp !== 4'd5) begin errors++; $display("FAIL hit_hp: got %0d want 5", char_hp); end
        checks++; if (hit_pulse !== 1'b1 || invuln !== 1'b1) begin
            errors++; $display("FAIL hit_flags: hit=%b inv=%b want 1/1", hit_pulse, invuln); end
        step();
        checks++; if (hit_pulse !== 1'b0 || req_ack !== 4'b0) begin
            errors++; $display("FAIL hit_pulse_len: hit=%b ack=%b want 0", hit_pulse, req_ack); end
        ticks(59);
        checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL iframe_59: inv=%b want 1", invuln); end
        ticks(1);
        checks++; if (invuln !== 1'b0 || char_hp !== 4'd5) begin
            errors++; $display("FAIL iframe_60: inv=%b hp=%0d want 0/5", invuln, char_hp); end
    endtask

    task automatic test_round_robin();
        do_start();
        req_valid = 4'b1111; req_amt = 16'h4321;
        step();
        req_valid = 4'b1110;
        checks++; if (req_ack !== 4'b0001 || char_hp !== 4'd7 || hit_pulse !== 1'b1) begin
            errors++; $display("FAIL rr_g0: ack=%b hp=%0d hit=%b want 0001/7/1", req_ack, char_hp, hit_pulse); end
        step();
        req_valid = 4'b1100;
        checks++; if (req_ack !== 4'b0010 || char_hp !== 4'd7 || hit_pulse !== 1'b0) begin
            errors++; $display("FAIL rr_g1: ack=%b hp=%0d hit=%b want 0010/7/0", req_ack, char_hp, hit_pulse); end
        step();
        req_valid = 4'b1000;
        checks++; if (req_ack !== 4'b0100 || char_hp !== 4'd7) begin
            errors++; $display("FAIL rr_g2: ack=%b hp=%0d want 0100/7", req_ack, char_hp); end
        step();
        req_valid = 4'b0000;
        checks++; if (req_ack !== 4'b1000 || char_hp !== 4'd7 || invuln !== 1'b1) begin
            errors++; $display("FAIL rr_g3: ack=%b hp=%0d inv=%b want 1000/7/1", req_ack, char_hp, invuln); end
        step();
        checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL rr_idle: got %b want 0000", req_ack); end
    endtask

    task automatic test_heal_and_freeze();
        heal_valid = 1'b1; heal_amt = 4'd7;
        step();
        heal_valid = 1'b0;
        checks++; if (char_hp !== 4'd8 || invuln !== 1'b1) begin
            errors++; $display("FAIL heal_sat: hp=%0d inv=%b want 8/1", char_hp, invuln); end
        game_active = 2'b10; req_valid = 4'b0001; req_amt = 16'h0001;
        ticks(10);
        checks++; if (req_ack !== 4'b0 || char_hp !== 4'd8 || invuln !== 1'b1) begin
            errors++; $display("FAIL freeze: ack=%b hp=%0d inv=%b want 0000/8/1", req_ack, char_hp, invuln); end
        req_valid = 4'b0; game_active = GAME_RUN;
        // i-frame count must be untouched by both the heal and the freeze
        ticks(59);
        checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL freeze_hold: inv=%b want 1", invuln); end
        ticks(1);
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL freeze_expire: inv=%b want 0", invuln); end
    endtask

    task automatic test_zero_and_combo();
        req_valid = 4'b0001; req_amt = 16'h0000;
        step();
        req_valid = 4'b0;
        checks++; if (req_ack !== 4'b0001 || char_hp !== 4'd8 || hit_pulse !== 1'b0 || invuln !== 1'b0) begin
            errors++; $display("FAIL zero_amt: ack=%b hp=%0d hit=%b inv=%b want 0001/8/0/0",
                               req_ack, char_hp, hit_pulse, invuln); end
        req_valid = 4'b0010; req_amt = 16'h0060; heal_valid = 1'b1; heal_amt = 4'd3;
        step();
        req_valid = 4'b0; heal_valid = 1'b0;
        checks++; if (req_ack !== 4'b0010 || char_hp !== 4'd5 || hit_pulse !== 1'b1 || invuln !== 1'b1) begin
            errors++; $display("FAIL dmg_heal: ack=%b hp=%0d hit=%b inv=%b want 0010/5/1/1",
                               req_ack, char_hp, hit_pulse, invuln); end
        ticks(60);
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL combo_expire: inv=%b want 0", invuln); end
    endtask

    task automatic test_fatal();
        req_valid = 4'b0100; req_amt = 16'h0700; heal_valid = 1'b1; heal_amt = 4'd4;
        step();
        req_valid = 4'b0; heal_valid = 1'b0;
        checks++; if (char_hp !== 4'd0 || char_dead !== 1'b1 || hit_pulse !== 1'b1 || invuln !== 1'b0) begin
            errors++; $display("FAIL fatal: hp=%0d dead=%b hit=%b inv=%b want 0/1/1/0",
                               char_hp, char_dead, hit_pulse, invuln); end
        checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL fatal_ack: got %b want 0100", req_ack); end
        req_valid = 4'b1011; req_amt = 16'h1111; heal_valid = 1'b1; heal_amt = 4'd5;
        step();
        req_valid = 4'b0; heal_valid = 1'b0;
        checks++; if (req_ack !== 4'b1011 || char_hp !== 4'd0 || char_dead !== 1'b1 || hit_pulse !== 1'b0) begin
            errors++; $display("FAIL dead_discard: ack=%b hp=%0d dead=%b hit=%b want 1011/0/1/0",
                               req_ack, char_hp, char_dead, hit_pulse); end
`ifdef CHAR_DMG_HITCNT_EN
        checks++; if (hit_count !== 8'd3) begin errors++; $display("FAIL hit_count: got %0d want 3", hit_count); end
`else
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL hit_count: got %0d want 0", hit_count); end
`endif
        do_start();
        checks++; if (char_hp !== 4'd8 || char_dead !== 1'b0 || hit_count !== 8'd0) begin
            errors++; $display("FAIL restart: hp=%0d dead=%b cnt=%0d want 8/0/0", char_hp, char_dead, hit_count); end
    endtask

    initial begin
        frame_tick  = 1'b0;
        game_active = GAME_RUN;
        game_start  = 1'b0;
        req_valid   = 4'b0;
        req_amt     = 16'h0;
        heal_valid  = 1'b0;
        heal_amt    = 4'd0;
        test_reset();
        test_single_hit();
        test_round_robin();
        test_heal_and_freeze();
        test_zero_and_combo();
        test_fatal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
